// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t  - loader FSM states
//   BYTES_PER_WORD  - bytes packed into one instruction word
//   BYTE_WIDTH      - width of one host byte
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_WIDTH     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone,
        StError
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles host bytes little-endian into one instruction word.
//   clk   - clock
//   rst   - asynchronous active-low reset
//   clr   - discard the partial word and restart at lane 0
//   push  - accept data into the current lane
//   data  - incoming byte
//   word  - lane register with the incoming byte merged into the current lane
//   full  - current lane is the top lane, so a push completes the word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic                                 push,
    input  logic [BYTE_WIDTH-1:0]                data,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] word,
    output logic                                 full
);

    localparam int unsigned IdxWidth = $clog2(BYTES_PER_WORD);

    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] lanes_q;
    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] lanes_merged;
    logic [IdxWidth-1:0]                       idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (clr) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (push) begin
            lanes_q[idx_q] <= data;
            idx_q          <= idx_q + IdxWidth'(1);
        end
    end

    // Lanes above the current index are still zero, which gives the
    // zero fill of a short final word for free.
    always_comb begin
        lanes_merged        = lanes_q;
        lanes_merged[idx_q] = data;
    end

    assign word = lanes_merged;
    assign full = (idx_q == IdxWidth'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes instruction memory from a host byte stream and holds the
// CPU until the load completes.
//   clk, rst       - clock; asynchronous active-low reset
//   start          - one-cycle request to begin a (re)load
//   byte_valid/data/last, byte_ready - host byte handshake
//   we, WA, WD     - instruction-memory write port (byte address, 4-byte stride)
//   words_loaded   - words written in the current/last load
//   done, error    - clean finish / overflow beyond WORD_COUNT
//   cpu_hold       - keep CPU in reset while high
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WORD_COUNT    = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         byte_valid,
    input  logic [BYTE_WIDTH-1:0]        byte_data,
    input  logic                         byte_last,
    output logic                         byte_ready,
    output logic                         we,
    output logic [ADDRESS_WIDTH-1:0]     WA,
    output logic [DATA_WIDTH-1:0]        WD,
    output logic [$clog2(WORD_COUNT):0]  words_loaded,
    output logic                         done,
    output logic                         error,
    output logic                         cpu_hold
);

    localparam int unsigned CountWidth = $clog2(WORD_COUNT) + 1;
    localparam logic [CountWidth-1:0] MaxCount = CountWidth'(WORD_COUNT);

    loader_state_t                       state_q, state_d;
    logic [CountWidth-1:0]               count_q, count_d;
    logic [ADDRESS_WIDTH-1:0]            wa_q, wa_d;
    logic [DATA_WIDTH-1:0]               wd_q, wd_d;
    logic                                last_q, last_d;
    logic                                push, clr, full;
    logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] packed_word;

    byte_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .push (push),
        .data (byte_data),
        .word (packed_word),
        .full (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        last_d  = last_q;
        push    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StLoad;
                    count_d = '0;
                    clr     = 1'b1;
                end
            end
            StLoad: begin
                // byte_ready is 1 throughout LOAD, so valid alone completes the handshake.
                if (byte_valid) begin
                    if (count_q == MaxCount) begin
                        // Memory is full: drop the byte rather than wrap the address.
                        state_d = StError;
                    end else begin
                        push = 1'b1;
                        if (full || byte_last) begin
                            // Capture the write now so WA/WD hold their values after WRITE.
                            state_d = StWrite;
                            wa_d    = ADDRESS_WIDTH'(count_q) << 2;
                            wd_d    = DATA_WIDTH'(packed_word);
                            last_d  = byte_last;
                        end
                    end
                end
            end
            StWrite: begin
                count_d = count_q + CountWidth'(1);
                clr     = 1'b1;
                state_d = last_q ? StDone : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_ready   = (state_q == StLoad);
    assign we           = (state_q == StWrite);
    assign WA           = wa_q;
    assign WD           = wd_q;
    assign words_loaded = count_q;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StError);
    assign cpu_hold     = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, byte_valid, byte_last;
    logic [7:0]  byte_data;
    logic        byte_ready, we, done, error, cpu_hold;
    logic [31:0] WA, WD;
    logic [8:0]  words_loaded;

    // Small instance used for the overflow case.
    logic        s_start, s_valid, s_last;
    logic [7:0]  s_data;
    logic        s_ready, s_we, s_done, s_error, s_hold;
    logic [31:0] s_wa, s_wd;
    logic [1:0]  s_words;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_viol = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] s_addr[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .we           (we),
        .WA           (WA),
        .WD           (WD),
        .words_loaded (words_loaded),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold)
    );

    imem_loader #(.WORD_COUNT(2)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .start        (s_start),
        .byte_valid   (s_valid),
        .byte_data    (s_data),
        .byte_last    (s_last),
        .byte_ready   (s_ready),
        .we           (s_we),
        .WA           (s_wa),
        .WD           (s_wd),
        .words_loaded (s_words),
        .done         (s_done),
        .error        (s_error),
        .cpu_hold     (s_hold)
    );

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(WA);
            wr_data.push_back(WD);
            if (byte_ready) ready_viol++;
        end
        if (s_we) s_addr.push_back(s_wa);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Hold the byte until accepted; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", (n < 50), 1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
        s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_ready", byte_ready, 0);
        check("rst_we", we, 0);
        check("rst_wa", WA, 0);
        check("rst_wd", WD, 0);
        check("rst_words", words_loaded, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_hold", cpu_hold, 1);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", byte_ready, 0);

        // Two-word program
        do_start();
        check("load_ready", byte_ready, 1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 1);
        check("t1_we", we, 1);
        check("t1_wa_live", WA, 32'h4);
        check("t1_wd_live", WD, 32'h00100093);
        check("t1_done_early", done, 0);
        check("t1_ready_write", byte_ready, 0);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_hold", cpu_hold, 0);
        check("t1_words", words_loaded, 2);
        check("t1_nwr", wr_addr.size(), 2);
        check("t1_a0", at(wr_addr, 0), 32'h0);
        check("t1_d0", at(wr_data, 0), 32'h00000013);
        check("t1_a1", at(wr_addr, 1), 32'h4);
        check("t1_d1", at(wr_data, 1), 32'h00100093);
        @(negedge clk);
        check("t1_wa_hold", WA, 32'h4);

        // Short final word, zero fill
        wr_addr.delete(); wr_data.delete();
        do_start();
        send_byte(8'hAA, 0); send_byte(8'hBB, 1);
        @(negedge clk);
        check("t2_nwr", wr_addr.size(), 1);
        check("t2_a0", at(wr_addr, 0), 32'h0);
        check("t2_d0", at(wr_data, 0), 32'h0000BBAA);
        check("t2_done", done, 1);
        check("t2_words", words_loaded, 1);

        // Reload from DONE
        wr_addr.delete(); wr_data.delete();
        do_start();
        check("t6_hold", cpu_hold, 1);
        check("t6_done_clr", done, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 1);
        @(negedge clk);
        check("t6_nwr", wr_addr.size(), 1);
        check("t6_a0", at(wr_addr, 0), 32'h0);
        check("t6_d0", at(wr_data, 0), 32'hDEADBEEF);
        check("t6_words", words_loaded, 1);
        check("t6_done", done, 1);

        // Stream with valid gaps, 11 bytes
        wr_addr.delete(); wr_data.delete();
        ready_viol = 0;
        do_start();
        for (int k = 0; k < 11; k++) begin
            send_byte(8'(8'h10 + k), (k == 10));
            if (k % 3 == 1) @(negedge clk);
        end
        @(negedge clk);
        check("t3_nwr", wr_addr.size(), 3);
        check("t3_d0", at(wr_data, 0), 32'h13121110);
        check("t3_d1", at(wr_data, 1), 32'h17161514);
        check("t3_d2", at(wr_data, 2), 32'h001A1918);
        check("t3_a2", at(wr_addr, 2), 32'h8);
        check("t3_ready_in_write", ready_viol, 0);
        check("t3_words", words_loaded, 3);

        // Reset mid-load after 6 bytes
        wr_addr.delete(); wr_data.delete();
        do_start();
        for (int k = 1; k <= 6; k++) send_byte(8'(k), 0);
        check("t5_nwr_pre", wr_addr.size(), 1);
        rst = 1'b0;
        #1;
        check("t5_ready", byte_ready, 0);
        check("t5_we", we, 0);
        check("t5_wa", WA, 0);
        check("t5_wd", WD, 0);
        check("t5_words", words_loaded, 0);
        check("t5_done", done, 0);
        check("t5_error", error, 0);
        check("t5_hold", cpu_hold, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_nwr_rst", wr_addr.size(), 1);
        do_start();
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
        @(negedge clk);
        check("t5_nwr", wr_addr.size(), 2);
        check("t5_a1", at(wr_addr, 1), 32'h0);
        check("t5_d1", at(wr_data, 1), 32'h44332211);
        check("t5_words_after", words_loaded, 1);

        // Overflow with WORD_COUNT=2
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            int n = 0;
            s_valid = 1'b1;
            s_data  = 8'(k);
            while (!s_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("s_ready_wait", (n < 50), 1);
            @(negedge clk);
            s_valid = 1'b0;
        end
        check("ov_error", s_error, 1);
        check("ov_hold", s_hold, 1);
        check("ov_done", s_done, 0);
        check("ov_ready", s_ready, 0);
        check("ov_words", s_words, 2);
        repeat (3) @(negedge clk);
        check("ov_nwr", s_addr.size(), 2);
        check("ov_a0", at(s_addr, 0), 32'h0);
        check("ov_a1", at(s_addr, 1), 32'h4);
        check("ov_wd_hold", s_wd, 32'h07060504);
        check("ov_error_stay", s_error, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
